// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX pipeline register: default widths, payload layout, slot-state encoding.
package id_ex_pkg;

  localparam int DATA_WIDTH_D = 32;
  localparam int SIZEOP_D     = 6;
  localparam int REG_ADDR_W_D = 5;
  localparam int EX_W_D       = 4;
  localparam int MEM_W_D      = 3;
  localparam int WB_W_D       = 2;

  // Field order here is the packing order used by id_ex_stage.
  typedef struct packed {
    logic [DATA_WIDTH_D-1:0] regA;
    logic [DATA_WIDTH_D-1:0] regB;
    logic [DATA_WIDTH_D-1:0] extendido;
    logic [SIZEOP_D-1:0]     opcode;
    logic [REG_ADDR_W_D-1:0] rs;
    logic [REG_ADDR_W_D-1:0] rt;
    logic [REG_ADDR_W_D-1:0] rd;
    logic [EX_W_D-1:0]       ex;
    logic [MEM_W_D-1:0]      mem;
    logic [WB_W_D-1:0]       wb;
  } id_ex_payload_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  function automatic int payload_width(input int dw, input int op, input int ra,
                                       input int ex, input int mem, input int wb);
    return 3 * dw + op + 3 * ra + ex + mem + wb;
  endfunction

endpackage

// File: rtl/id_ex_slot.sv
// Payload register with load enable and synchronous active-low clear.
module id_ex_slot #(
  parameter int W = 1
) (
  input  logic         i_clock,
  input  logic         i_clear_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clock) begin
    if (!i_clear_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_stage.sv
// Elastic ID/EX pipeline register with valid/ready handshake, flush and bubble insertion.
// Define ID_EX_SKID_EN for the two-slot skid build with a registered o_ready.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SIZEOP     = 6,
  parameter int REG_ADDR_W = 5,
  parameter int EX_W       = 4,
  parameter int MEM_W      = 3,
  parameter int WB_W       = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_regA,
  input  logic [DATA_WIDTH-1:0] i_regB,
  input  logic [DATA_WIDTH-1:0] i_extendido,
  input  logic [SIZEOP-1:0]     i_opcode,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [EX_W-1:0]       i_ex,
  input  logic [MEM_W-1:0]      i_mem,
  input  logic [WB_W-1:0]       i_wb,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_regA,
  output logic [DATA_WIDTH-1:0] o_regB,
  output logic [DATA_WIDTH-1:0] o_extendido,
  output logic [SIZEOP-1:0]     o_opcode,
  output logic [REG_ADDR_W-1:0] o_rs,
  output logic [REG_ADDR_W-1:0] o_rt,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [EX_W-1:0]       o_ex,
  output logic [MEM_W-1:0]      o_mem,
  output logic [WB_W-1:0]       o_wb
);

  localparam int PW = payload_width(DATA_WIDTH, SIZEOP, REG_ADDR_W, EX_W, MEM_W, WB_W);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_load_m;
  logic [PW-1:0]     w_in;
  logic [PW-1:0]     w_m_d;
  logic [PW-1:0]     w_m_q;
  logic [EX_W-1:0]   w_ex_q;
  logic [MEM_W-1:0]  w_mem_q;
  logic [WB_W-1:0]   w_wb_q;

  assign w_in = {i_regA, i_regB, i_extendido, i_opcode, i_rs, i_rt, i_rd, i_ex, i_mem, i_wb};

  assign w_valid    = (r_state != EMPTY);
  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = w_valid & i_ready;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

`ifdef ID_EX_SKID_EN
  logic          r_ready;
  logic          w_load_s;
  logic          w_m_from_s;
  logic [PW-1:0] w_s_q;

  always_comb begin
    w_state_next = r_state;
    w_load_m     = 1'b0;
    w_load_s     = 1'b0;
    w_m_from_s   = 1'b0;
    if (i_flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_in_fire) begin
          w_state_next = ONE;
          w_load_m     = 1'b1;
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_load_m = 1'b1;
          end else if (w_in_fire) begin
            w_state_next = FULL;
            w_load_s     = 1'b1;
          end else if (w_out_fire) begin
            w_state_next = EMPTY;
          end
        end
        FULL: if (w_out_fire) begin
          w_state_next = ONE;
          w_load_m     = 1'b1;
          w_m_from_s   = 1'b1;
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

  // Ready is a pure flop, computed from where the FSM will be next cycle.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_ready <= 1'b1;
    end else begin
      r_ready <= (w_state_next != FULL);
    end
  end

  assign o_ready = r_ready;
  assign w_m_d   = w_m_from_s ? w_s_q : w_in;

  id_ex_slot #(.W(PW)) u_slot_s (
    .i_clock   (i_clock),
    .i_clear_n (i_reset),
    .i_load    (w_load_s),
    .i_d       (w_in),
    .o_q       (w_s_q)
  );
`else
  always_comb begin
    w_state_next = r_state;
    w_load_m     = 1'b0;
    if (i_flush) begin
      w_state_next = EMPTY;
    end else if (w_in_fire) begin
      w_state_next = ONE;
      w_load_m     = 1'b1;
    end else if (w_out_fire) begin
      w_state_next = EMPTY;
    end
  end

  assign o_ready = !w_valid | i_ready;
  assign w_m_d   = w_in;
`endif

  id_ex_slot #(.W(PW)) u_slot_m (
    .i_clock   (i_clock),
    .i_clear_n (i_reset),
    .i_load    (w_load_m),
    .i_d       (w_m_d),
    .o_q       (w_m_q)
  );

  assign {o_regA, o_regB, o_extendido, o_opcode, o_rs, o_rt, o_rd, w_ex_q, w_mem_q, w_wb_q} = w_m_q;

  // Control groups become a bubble whenever nothing valid is presented.
  assign o_valid = w_valid;
  assign o_ex    = w_valid ? w_ex_q  : '0;
  assign o_mem   = w_valid ? w_mem_q : '0;
  assign o_wb    = w_valid ? w_wb_q  : '0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized scoreboard bench for id_ex_stage; works for either build of ID_EX_SKID_EN.
module tb_id_ex_stage;
  import id_ex_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_ready;
  logic        o_valid;
  id_ex_payload_t p_in;
  id_ex_payload_t p_out;

  logic [31:0] o_regA, o_regB, o_extendido;
  logic [5:0]  o_opcode;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [3:0]  o_ex;
  logic [2:0]  o_mem;
  logic [1:0]  o_wb;

  int checks = 0;
  int failures = 0;

  id_ex_payload_t exp_q[$];
  id_ex_payload_t last_m;
  bit             flush_pend = 1'b0;

  always #5 i_clock = ~i_clock;

  id_ex_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_flush(i_flush),
    .i_regA(p_in.regA), .i_regB(p_in.regB), .i_extendido(p_in.extendido),
    .i_opcode(p_in.opcode), .i_rs(p_in.rs), .i_rt(p_in.rt), .i_rd(p_in.rd),
    .i_ex(p_in.ex), .i_mem(p_in.mem), .i_wb(p_in.wb),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_regA(o_regA), .o_regB(o_regB), .o_extendido(o_extendido), .o_opcode(o_opcode),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_ex(o_ex), .o_mem(o_mem), .o_wb(o_wb)
  );

  assign p_out = {o_regA, o_regB, o_extendido, o_opcode, o_rs, o_rt, o_rd, o_ex, o_mem, o_wb};

  function void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic id_ex_payload_t rand_pl(input logic [31:0] regA);
    logic [127:0] r;
    id_ex_payload_t p;
    r = {$urandom, $urandom, $urandom, $urandom};
    p = r[$bits(id_ex_payload_t)-1:0];
    p.regA = regA;
    return p;
  endfunction

  // Monitor: compares the head of the expected stream whenever the stage presents data.
  always @(negedge i_clock) begin
    if (i_reset) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 128'(o_valid), 128'(0));
        end else begin
          chk("payload", 128'(p_out), 128'(exp_q[0]));
          last_m = exp_q[0];
          if (i_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("bubble_ctrl", 128'({o_ex, o_mem, o_wb}), 128'(0));
        chk("hold_data", 128'({o_regA, o_rd}), 128'({last_m.regA, last_m.rd}));
      end
      if (flush_pend) begin
        exp_q.delete();
        flush_pend = 1'b0;
      end
    end
  end

  // One cycle of stimulus; the expected item is queued if the stage accepts it.
  task automatic step(input bit v, input id_ex_payload_t p, input bit fl, input bit rdy);
    bit exp_ready;
    @(posedge i_clock);
    #1;
    i_valid = v; p_in = p; i_flush = fl; i_ready = rdy;
    #1;
`ifdef ID_EX_SKID_EN
    exp_ready = (exp_q.size() < 2);
`else
    exp_ready = (exp_q.size() == 0) || rdy;
`endif
    chk("o_ready", 128'(o_ready), 128'(exp_ready));
    chk("o_valid", 128'(o_valid), 128'(exp_q.size() != 0));
    if (fl) flush_pend = 1'b1;
    else if (v && o_ready) exp_q.push_back(p);
  endtask

  task automatic do_reset(input int n);
    @(posedge i_clock);
    #1;
    i_reset = 1'b0; i_valid = 1'b1; i_flush = 1'b0; p_in = rand_pl(32'h5555);
    exp_q.delete(); flush_pend = 1'b0; last_m = '0;
    repeat (n) @(posedge i_clock);
    #1;
    i_reset = 1'b1; i_valid = 1'b0;
    #1;
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_wb", 128'(o_wb), 128'(0));
    chk("rst_regA", 128'(o_regA), 128'(0));
    chk("rst_payload", 128'(p_out), 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(1));
  endtask

  initial begin
    id_ex_payload_t p;
    p_in = '0;
    last_m = '0;
    do_reset(2);

    // Streaming, no gaps.
    step(1, rand_pl(32'h11), 0, 1);
    step(1, rand_pl(32'h22), 0, 1);
    step(1, rand_pl(32'h33), 0, 1);
    step(0, rand_pl(32'h0), 0, 1);
    step(0, rand_pl(32'h0), 0, 1);

    // Stall then release.
    step(1, rand_pl(32'hA), 0, 0);
    step(1, rand_pl(32'hB), 0, 0);
    step(0, rand_pl(32'h0), 0, 0);
    repeat (4) step(0, rand_pl(32'h0), 0, 1);

    // Flush while held full, with a simultaneous offer that must vanish.
    step(1, rand_pl(32'h1), 0, 0);
    step(1, rand_pl(32'h2), 0, 0);
    step(1, rand_pl(32'hC), 1, 0);
    repeat (3) step(0, rand_pl(32'h0), 0, 1);

    // Bubble after a consumed instruction with all-ones control.
    p = rand_pl(32'h77);
    p.ex = 4'hF; p.wb = 2'b11;
    step(1, p, 0, 1);
    repeat (3) step(0, rand_pl(32'h0), 0, 1);

    // Non-skid: accept and release on the same cycle reloads M.
    step(1, rand_pl(32'h40), 0, 0);
    step(1, rand_pl(32'h41), 0, 0);
    step(1, rand_pl(32'h42), 0, 1);
    repeat (3) step(0, rand_pl(32'h0), 0, 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_pl($urandom),
           $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    end
    repeat (3) step(0, rand_pl(32'h0), 0, 1);

    // Reset during a stall discards everything held.
    step(1, rand_pl(32'hD1), 0, 0);
    step(1, rand_pl(32'hD2), 0, 0);
    do_reset(1);
    repeat (3) step(0, rand_pl(32'h0), 0, 1);
    step(1, rand_pl(32'hE1), 0, 1);
    repeat (2) step(0, rand_pl(32'h0), 0, 1);

    @(negedge i_clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
